// File: rtl/ex_wb_regfile_pkg.sv
// ============================================================================
// Module  : ex_wb_regfile_pkg
// Brief   : Shared widths and EX/WB latch control decode for ex_wb_regfile.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ex_wb_regfile_pkg;

  localparam int c_DATA_W = 32;
  localparam int c_ADDR_W = 5;
  localparam int c_NREG   = 32;
  localparam int c_CNT_W  = 32;

  typedef enum logic [1:0] {
    LATCH_LOAD   = 2'd0,
    LATCH_BUBBLE = 2'd1,
    LATCH_FLUSH  = 2'd2
  } latch_op_e;

  // Flush outranks stall; both leave the latch empty.
  function automatic latch_op_e latch_op(input logic flush, input logic stall);
    if (flush) return LATCH_FLUSH;
    if (stall) return LATCH_BUBBLE;
    return LATCH_LOAD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_wb_regfile_if.sv
// ============================================================================
// Module  : ex_wb_regfile_if
// Brief   : Execute-result, read-port and write-back status bundle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface ex_wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] wd_i;
  logic              wreg_i;
  logic [DATA_W-1:0] wdata_i;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [ADDR_W-1:0] wb_wd_o;
  logic              wb_wreg_o;
  logic [DATA_W-1:0] wb_wdata_o;
  logic [31:0]       wr_count_o;

  modport master (
    output stall, flush, wd_i, wreg_i, wdata_i, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, wb_wd_o, wb_wreg_o, wb_wdata_o, wr_count_o
  );

  modport slave (
    input  stall, flush, wd_i, wreg_i, wdata_i, re1, raddr1, re2, raddr2,
    output rdata1, rdata2, wb_wd_o, wb_wreg_o, wb_wdata_o, wr_count_o
  );
endinterface

`default_nettype wire

// File: rtl/ex_wb_regfile_regfile_2r1w.sv
// ============================================================================
// Module  : ex_wb_regfile_regfile_2r1w
// Brief   : Register array, one write port, two raw read ports, r0 fixed at 0.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_wb_regfile_regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_we,
  input  wire logic [ADDR_W-1:0] i_waddr,
  input  wire logic [DATA_W-1:0] i_wdata,
  input  wire logic [ADDR_W-1:0] i_raddr1,
  input  wire logic [ADDR_W-1:0] i_raddr2,
  output logic      [DATA_W-1:0] o_rdata1,
  output logic      [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] w_regs [NREG];

  // Entry 0 has no storage, so no write path can ever alter it.
  assign w_regs[0] = '0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q <= '0;
      end else if (i_we && (i_waddr == ADDR_W'(gi))) begin
        r_q <= i_wdata;
      end
    end

    assign w_regs[gi] = r_q;
  end

  assign o_rdata1 = w_regs[i_raddr1];
  assign o_rdata2 = w_regs[i_raddr2];

endmodule

`default_nettype wire

// File: rtl/ex_wb_regfile.sv
// ============================================================================
// Module  : ex_wb_regfile
// Brief   : EX/WB latch, commit counter and bypassed two-port register file.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_wb_regfile
  import ex_wb_regfile_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int ADDR_W = c_ADDR_W,
  parameter int NREG   = c_NREG
) (
  input wire logic        clk,
  input wire logic        rst,
  ex_wb_regfile_if.slave  bus
);

  logic [ADDR_W-1:0]  r_wb_wd;
  logic               r_wb_wreg;
  logic [DATA_W-1:0]  r_wb_wdata;
  logic [c_CNT_W-1:0] r_wr_count;

  latch_op_e          w_op;
  logic               w_commit;
  logic [DATA_W-1:0]  w_arr_rdata1;
  logic [DATA_W-1:0]  w_arr_rdata2;

  assign w_op     = latch_op(bus.flush, bus.stall);
  assign w_commit = r_wb_wreg && (r_wb_wd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_wd    <= '0;
      r_wb_wreg  <= 1'b0;
      r_wb_wdata <= '0;
    end else begin
      case (w_op)
        LATCH_LOAD: begin
          r_wb_wd    <= bus.wd_i;
          r_wb_wreg  <= bus.wreg_i;
          r_wb_wdata <= bus.wdata_i;
        end
        default: begin
          r_wb_wd    <= '0;
          r_wb_wreg  <= 1'b0;
          r_wb_wdata <= '0;
        end
      endcase
    end
  end

  // The commit uses the latch contents from before this edge, so a flush or
  // stall arriving on the same edge cannot cancel it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_count <= '0;
    end else if (w_commit) begin
      r_wr_count <= r_wr_count + 1'b1;
    end
  end

  ex_wb_regfile_regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_commit),
    .i_waddr  (r_wb_wd),
    .i_wdata  (r_wb_wdata),
    .i_raddr1 (bus.raddr1),
    .i_raddr2 (bus.raddr2),
    .o_rdata1 (w_arr_rdata1),
    .o_rdata2 (w_arr_rdata2)
  );

  logic              w_re    [2];
  logic [ADDR_W-1:0] w_raddr [2];
  logic [DATA_W-1:0] w_arr   [2];
  logic [DATA_W-1:0] w_rdata [2];

  assign w_re[0]    = bus.re1;
  assign w_re[1]    = bus.re2;
  assign w_raddr[0] = bus.raddr1;
  assign w_raddr[1] = bus.raddr2;
  assign w_arr[0]   = w_arr_rdata1;
  assign w_arr[1]   = w_arr_rdata2;

  for (genvar gp = 0; gp < 2; gp++) begin : g_rd_port
    // Only the latched entry is bypassed; execute-stage forwarding lives in decode.
    always_comb begin
      w_rdata[gp] = '0;
      if (rst || !w_re[gp] || (w_raddr[gp] == '0)) begin
        w_rdata[gp] = '0;
      end else if (r_wb_wreg && (r_wb_wd == w_raddr[gp])) begin
        w_rdata[gp] = r_wb_wdata;
      end else begin
        w_rdata[gp] = w_arr[gp];
      end
    end
  end

  assign bus.rdata1     = w_rdata[0];
  assign bus.rdata2     = w_rdata[1];
  assign bus.wb_wd_o    = r_wb_wd;
  assign bus.wb_wreg_o  = r_wb_wreg;
  assign bus.wb_wdata_o = r_wb_wdata;
  assign bus.wr_count_o = r_wr_count;

endmodule

`default_nettype wire

// File: tb/tb_ex_wb_regfile.sv
// ============================================================================
// Module  : tb_ex_wb_regfile
// Brief   : Randomized and directed self-checking bench for ex_wb_regfile.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_wb_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_wb_regfile_if bus ();

  ex_wb_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Reference state: architectural registers plus at most one pending write.
  logic [31:0] m_regs [32];
  logic [4:0]  m_wd     = '0;
  logic        m_wreg   = 1'b0;
  logic [31:0] m_wdata  = '0;
  bit          m_known  = 1'b1;
  logic [31:0] m_count  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_read(input logic re, input logic [4:0] a);
    if (rst || !re || a == 5'd0) return 32'd0;
    if (m_wreg && m_wd == a)     return m_wdata;
    return m_regs[a];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_wd = '0; m_wreg = 1'b0; m_wdata = '0; m_known = 1'b1; m_count = '0;
    end else begin
      if (m_wreg && m_wd != 5'd0) begin
        m_regs[m_wd] = m_wdata;
        m_count      = m_count + 32'd1;
      end
      if (bus.flush) begin
        m_wd = '0; m_wreg = 1'b0; m_wdata = '0; m_known = 1'b1;
      end else if (!bus.stall) begin
        m_wd = bus.wd_i; m_wreg = bus.wreg_i; m_wdata = bus.wdata_i; m_known = 1'b1;
      end else begin
        m_wreg = 1'b0; m_known = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rdata1",    bus.rdata1,     exp_read(bus.re1, bus.raddr1));
      chk("rdata2",    bus.rdata2,     exp_read(bus.re2, bus.raddr2));
      chk("wb_wreg",   {31'd0, bus.wb_wreg_o}, {31'd0, m_wreg});
      chk("wr_count",  bus.wr_count_o, m_count);
      if (m_known || m_wreg) begin
        chk("wb_wd",    {27'd0, bus.wb_wd_o}, {27'd0, m_wd});
        chk("wb_wdata", bus.wb_wdata_o,       m_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic fl, input logic [4:0] wd,
                       input logic we, input logic [31:0] wdat);
    bus.stall = st; bus.flush = fl; bus.wd_i = wd; bus.wreg_i = we; bus.wdata_i = wdat;
  endtask

  initial begin
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    bus.re1 = 1'b0; bus.raddr1 = '0; bus.re2 = 1'b0; bus.raddr2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0;
    cmp_en = 1'b1;
    #1;
    chk("reset_wr_count", bus.wr_count_o, 32'd0);
    chk("reset_wb_wreg",  {31'd0, bus.wb_wreg_o}, 32'd0);

    // Basic write with bypass then array read.
    bus.re1 = 1'b1; bus.raddr1 = 5'd3;
    drive(1'b0, 1'b0, 5'd3, 1'b1, 32'hDEADBEEF);
    tick();
    chk("basic_bypass", bus.rdata1, 32'hDEADBEEF);
    chk("basic_cnt0",   bus.wr_count_o, 32'd0);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    tick();
    chk("basic_array",  bus.rdata1, 32'hDEADBEEF);
    chk("basic_cnt1",   bus.wr_count_o, 32'd1);

    // Writes to r0 are dropped and not counted.
    bus.re2 = 1'b1; bus.raddr2 = 5'd0;
    drive(1'b0, 1'b0, 5'd0, 1'b1, 32'hFFFFFFFF);
    tick();
    chk("zero_rd_a", bus.rdata2, 32'd0);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    tick();
    chk("zero_rd_b", bus.rdata2, 32'd0);
    chk("zero_cnt",  bus.wr_count_o, 32'd1);

    // Stall holds off a held result for three cycles.
    bus.raddr1 = 5'd7;
    drive(1'b1, 1'b0, 5'd7, 1'b1, 32'hA5A5A5A5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_wreg", {31'd0, bus.wb_wreg_o}, 32'd0);
      chk("stall_r7",   bus.rdata1, 32'd0);
    end
    bus.stall = 1'b0;
    tick();
    chk("stall_release", bus.rdata1, 32'hA5A5A5A5);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    tick();
    chk("stall_cnt", bus.wr_count_o, 32'd2);

    // Flush+stall with a pending r9 entry: the pending commit still lands.
    bus.raddr1 = 5'd9;
    drive(1'b0, 1'b0, 5'd9, 1'b1, 32'h55);
    tick();
    drive(1'b1, 1'b1, 5'd9, 1'b1, 32'h66);
    tick();
    chk("flush_wreg",  {31'd0, bus.wb_wreg_o}, 32'd0);
    chk("flush_wd",    {27'd0, bus.wb_wd_o}, 32'd0);
    chk("flush_wdata", bus.wb_wdata_o, 32'd0);
    chk("flush_r9",    bus.rdata1, 32'h55);
    chk("flush_cnt",   bus.wr_count_o, 32'd3);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    tick();
    chk("flush_r9_after", bus.rdata1, 32'h55);

    // Back-to-back writes to r4 are visible each cycle via bypass.
    bus.raddr1 = 5'd4;
    for (int v = 1; v <= 3; v++) begin
      drive(1'b0, 1'b0, 5'd4, 1'b1, 32'(v));
      tick();
      chk("b2b_r4", bus.rdata1, 32'(v));
    end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    tick();
    chk("b2b_cnt", bus.wr_count_o, 32'd6);

    // Reset with r5 committed and r6 still pending.
    bus.raddr1 = 5'd5; bus.raddr2 = 5'd6;
    drive(1'b0, 1'b0, 5'd5, 1'b1, 32'h1234);
    tick();
    drive(1'b0, 1'b0, 5'd6, 1'b1, 32'hBEEF);
    tick();
    chk("pre_rst_r5", bus.rdata1, 32'h1234);
    chk("pre_rst_r6", bus.rdata2, 32'hBEEF);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_async_r5", bus.rdata1, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_r5",  bus.rdata1, 32'd0);
    chk("post_rst_r6",  bus.rdata2, 32'd0);
    chk("post_rst_cnt", bus.wr_count_o, 32'd0);
    chk("post_rst_wreg", {31'd0, bus.wb_wreg_o}, 32'd0);

    // Counter wrap from all-ones.
    force dut.r_wr_count = 32'hFFFFFFFF;
    m_count = 32'hFFFFFFFF;
    #1;
    release dut.r_wr_count;
    chk("wrap_preload", bus.wr_count_o, 32'hFFFFFFFF);
    drive(1'b0, 1'b0, 5'd2, 1'b1, 32'h77);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
    tick();
    chk("wrap_zero", bus.wr_count_o, 32'd0);

    // Randomized traffic, addresses biased low to exercise bypass hits.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #2;
      bus.stall   = ($urandom_range(0, 99) < 20);
      bus.flush   = ($urandom_range(0, 99) < 8);
      bus.wd_i    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      bus.wreg_i  = ($urandom_range(0, 99) < 70);
      bus.wdata_i = $urandom;
      bus.re1     = ($urandom_range(0, 9) != 0);
      bus.re2     = ($urandom_range(0, 9) != 0);
      bus.raddr1  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      bus.raddr2  = ($urandom_range(0, 3) == 0) ? bus.raddr1 : 5'($urandom_range(0, 7));
      if (c == 1500) begin
        rst = 1'b1;
        #3;
        rst = 1'b0;
      end
    end

    @(negedge clk); #1;
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
